// File: rtl/ram_arbiter.sv
// ram_arbiter: shares single-port main RAM between video, CPU and DMA with a DMA starvation guard
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic                  dma_we,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [1:0]            owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;
  localparam logic [1:0] G_NONE = 2'd0, G_VID = 2'd1, G_CPU = 2'd2, G_DMA = 2'd3;
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic ram_cs_q, ram_cs_d, ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0] owner_q, owner_d, gnt;
  logic vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic [DATA_WIDTH-1:0] vid_rdata_q, vid_rdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic starved, capture;
  // Winner selection, FSM next state, RAM command and starvation counter update
  always_comb begin
    starved     = dma_req && (cnt_q >= 8'(STARVE_LIMIT));
    gnt         = vid_req ? G_VID : starved ? G_DMA : cpu_req ? G_CPU : dma_req ? G_DMA : G_NONE;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    owner_d     = owner_q;
    capture     = (state_q == WAIT);
    case (state_q)
      IDLE: if (gnt != G_NONE) begin
        state_d     = ISSUE;
        ram_cs_d    = 1'b1;
        owner_d     = gnt;
        ram_addr_d  = gnt == G_VID ? vid_addr : gnt == G_CPU ? cpu_addr : dma_addr;
        ram_we_d    = gnt == G_CPU ? cpu_we : gnt == G_DMA ? dma_we : 1'b0;
        ram_wdata_d = gnt == G_CPU ? cpu_wdata : gnt == G_DMA ? dma_wdata : ram_wdata_q;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = ACK;
      default: state_d = IDLE;
    endcase
    if (!dma_req) cnt_d = 8'd0;
    else if (state_q == IDLE && gnt == G_DMA) cnt_d = 8'd0;
    else if (state_q == IDLE && gnt != G_NONE && cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
    vid_ack_d   = capture && owner_q == G_VID;
    cpu_ack_d   = capture && owner_q == G_CPU;
    dma_ack_d   = capture && owner_q == G_DMA;
    vid_rdata_d = vid_ack_d ? ram_rdata : vid_rdata_q;
    cpu_rdata_d = cpu_ack_d ? ram_rdata : cpu_rdata_q;
    dma_rdata_d = dma_ack_d ? ram_rdata : dma_rdata_q;
  end
  // State and all registered outputs, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      owner_q     <= G_NONE;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      owner_q     <= owner_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign owner     = owner_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign vid_rdata = vid_rdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a read-first RAM model
module tb_ram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] vid_addr = '0, cpu_addr = '0, dma_addr = '0;
  logic [7:0] cpu_wdata = '0, dma_wdata = '0;
  logic vid_ack, cpu_ack, dma_ack, ram_cs, ram_we;
  logic [7:0] vid_rdata, cpu_rdata, dma_rdata, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic [15:0] ram_addr;
  logic [1:0] owner;
  logic [7:0] mem [0:65535];
  int checks = 0, errors = 0;

  ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Single-port read-first RAM: registered data_out returns the old contents on a write
  always @(posedge clk) begin
    if (ram_cs) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    checks++;
    if ({ram_cs, ram_we, ram_addr, ram_wdata, vid_ack, cpu_ack, dma_ack, vid_rdata, cpu_rdata, dma_rdata, owner} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cs=%b we=%b addr=%h owner=%0d acks=%b%b%b, want all 0",
               ram_cs, ram_we, ram_addr, owner, vid_ack, cpu_ack, dma_ack);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_cpu_write_read;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'hA5;
    step(1);
    checks++;
    if ({ram_cs, ram_we, ram_addr, ram_wdata, owner} !== {1'b1, 1'b1, 16'h0400, 8'hA5, 2'd2}) begin
      errors++;
      $display("FAIL cpu_wr_issue: got cs=%b we=%b addr=%h wdata=%h owner=%0d, want 1 1 0400 a5 2",
               ram_cs, ram_we, ram_addr, ram_wdata, owner);
    end
    step(1);
    checks++;
    if ({ram_cs, ram_we, cpu_ack} !== 3'b000) begin
      errors++;
      $display("FAIL cpu_wr_wait: got cs=%b we=%b ack=%b, want 0 0 0", ram_cs, ram_we, cpu_ack);
    end
    step(1);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL cpu_wr_ack: got ack=%b rdata=%h, want 1 00", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    step(1);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_ack_pulse: got ack=%b, want 0", cpu_ack);
    end
    cpu_req = 1'b1; cpu_we = 1'b0;
    step(1);
    checks++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rd_issue: got cs=%b we=%b, want 1 0", ram_cs, ram_we);
    end
    step(2);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_rd_ack: got ack=%b rdata=%h, want 1 a5", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    step(1);
  endtask

  task automatic test_priority;
    vid_req = 1'b1; vid_addr = 16'h0400;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h3C;
    step(1);
    checks++;
    if ({owner, ram_cs, ram_we, ram_addr} !== {2'd1, 1'b1, 1'b0, 16'h0400}) begin
      errors++;
      $display("FAIL prio_vid_issue: got owner=%0d cs=%b we=%b addr=%h, want 1 1 0 0400", owner, ram_cs, ram_we, ram_addr);
    end
    step(2);
    checks++;
    if (vid_ack !== 1'b1 || vid_rdata !== 8'hA5 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL prio_vid_ack: got vack=%b vrdata=%h cack=%b, want 1 a5 0", vid_ack, vid_rdata, cpu_ack);
    end
    vid_req = 1'b0;
    step(2);
    checks++;
    if ({owner, ram_cs, ram_we, ram_addr} !== {2'd2, 1'b1, 1'b1, 16'h0010}) begin
      errors++;
      $display("FAIL prio_cpu_issue: got owner=%0d cs=%b we=%b addr=%h, want 2 1 1 0010", owner, ram_cs, ram_we, ram_addr);
    end
    step(2);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h00 || vid_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL prio_cpu_ack: got cack=%b crdata=%h vrdata=%h, want 1 00 a5", cpu_ack, cpu_rdata, vid_rdata);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(1);
  endtask

  task automatic test_back_to_back;
    int acks = 0, cs = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    step(3);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_first_ack: got ack=%b rdata=%h, want 1 3c", cpu_ack, cpu_rdata);
    end
    cpu_addr = 16'h0400;
    step(1);
    checks++;
    if (ram_cs !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_state: got cs=%b ack=%b, want 0 0", ram_cs, cpu_ack);
    end
    step(1);
    checks++;
    if (ram_cs !== 1'b1 || ram_addr !== 16'h0400) begin
      errors++;
      $display("FAIL b2b_regrant: got cs=%b addr=%h, want 1 0400", ram_cs, ram_addr);
    end
    step(2);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL b2b_second_ack: got ack=%b rdata=%h, want 1 a5", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      acks += int'(cpu_ack);
      cs += int'(ram_cs);
    end
    checks++;
    if (acks != 0 || cs != 0) begin
      errors++;
      $display("FAIL b2b_no_extra: got acks=%0d cs_pulses=%0d, want 0 0", acks, cs);
    end
  endtask

  task automatic test_starvation;
    int n;
    bit got;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0010;
    for (int r = 0; r < 2; r++) begin
      n = 0; got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        step(1);
        n += int'(cpu_ack);
        got = dma_ack;
      end
      checks++;
      if (!got || n != 8 || dma_rdata !== 8'h3C) begin
        errors++;
        $display("FAIL starve_round%0d: got dma_ack_seen=%b cpu_grants=%0d drdata=%h, want 1 8 3c", r, got, n, dma_rdata);
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    step(1);
  endtask

  task automatic test_video_hog;
    int nv = 0, nd = 0;
    vid_req = 1'b1; vid_addr = 16'h0400;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0010;
    for (int i = 0; i < 2000 && nv < 260; i++) begin
      step(1);
      nv += int'(vid_ack);
      nd += int'(dma_ack);
    end
    checks++;
    if (nv != 260 || nd != 0) begin
      errors++;
      $display("FAIL hog_video_wins: got vid_acks=%0d dma_acks=%0d, want 260 0", nv, nd);
    end
    vid_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    step(2);
    checks++;
    if (owner !== 2'd3 || ram_addr !== 16'h0010) begin
      errors++;
      $display("FAIL hog_saturated_dma: got owner=%0d addr=%h, want 3 0010", owner, ram_addr);
    end
    step(2);
    checks++;
    if (dma_ack !== 1'b1 || dma_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL hog_dma_ack: got ack=%b rdata=%h, want 1 3c", dma_ack, dma_rdata);
    end
    dma_req = 1'b0;
    step(4);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL hog_cpu_after: got ack=%b rdata=%h, want 1 a5", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0800; cpu_wdata = 8'h5A;
    step(1);
    checks++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: got cs=%b we=%b, want 1 1", ram_cs, ram_we);
    end
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    step(1);
    checks++;
    if ({ram_cs, ram_we, ram_addr, ram_wdata, vid_ack, cpu_ack, dma_ack, vid_rdata, cpu_rdata, dma_rdata, owner} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got cs=%b we=%b addr=%h owner=%0d crdata=%h, want all 0",
               ram_cs, ram_we, ram_addr, owner, cpu_rdata);
    end
    acks += int'(cpu_ack);
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      acks += int'(cpu_ack);
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL mid_no_ack: got acks=%0d, want 0", acks);
    end
    cpu_req = 1'b1; cpu_addr = 16'h0800;
    step(3);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL mid_write_committed: got ack=%b rdata=%h, want 1 5a", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    step(1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset;
    test_cpu_write_read;
    test_priority;
    test_back_to_back;
    test_starvation;
    test_video_hog;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port main RAM between three requesters: video scanner (read-only), 6502 CPU, and DMA/loader (disk image, boot loader).
- Sits between the requesters and the main RAM instance. It drives the RAM's cs/addr/we/data_in and captures its registered data_out.
- RAM read is read-first: data_out is valid on the cycle after the access edge. On a write it returns the old contents.
- Fixed priority video > CPU > DMA, with a starvation guard that lets DMA win over CPU (never over video).

Parameters:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- STARVE_LIMIT, 8, consecutive lost arbitrations after which a waiting DMA request beats CPU (1..255).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- vid_req  in  1  video read request; held until vid_ack.
- vid_addr  in  ADDR_WIDTH  video read address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  DATA_WIDTH  read data; valid while vid_ack=1, held afterwards.
- cpu_req, cpu_addr, cpu_we, cpu_wdata  in  1/ADDR_WIDTH/1/DATA_WIDTH  CPU request bundle.
- cpu_ack, cpu_rdata  out  1/DATA_WIDTH  as video.
- dma_req, dma_addr, dma_we, dma_wdata  in  1/ADDR_WIDTH/1/DATA_WIDTH  DMA request bundle.
- dma_ack, dma_rdata  out  1/DATA_WIDTH  as video.
- ram_cs  out  1  to RAM cs.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_wdata  out  DATA_WIDTH  to RAM data_in.
- ram_rdata  in  DATA_WIDTH  from RAM data_out.
- owner  out  2  current/last grant: 0 none, 1 video, 2 CPU, 3 DMA.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; starvation counter is cleared.
  - Every output becomes 0, including ram_* outputs, all acks, all rdata and owner.
- State machine: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. One access per 4 cycles.
- IDLE:
  - If any req is sampled high, pick the winner and register its addr/we/wdata onto ram_*.
  - Set ram_cs=1 and owner; go to ISSUE.
  - ram_we is forced 0 for video.
  - With no req, stay in IDLE with ram_cs=0.
- ISSUE:
  - ram_cs is high for exactly this cycle; the RAM performs the access at the closing edge.
  - Next state is WAIT with ram_cs=0 and ram_we=0. ram_addr and ram_wdata are held.
- WAIT:
  - ram_rdata is valid. At the edge, capture it into the winner's rdata register, set the winner's ack=1, go to ACK.
- ACK:
  - The ack is high for exactly one cycle; at the edge it clears and the state goes to IDLE.
  - A requester must drop req, or present a new request, at the edge where it samples ack=1.
  - The arbiter never samples req during ACK, so no double grant can occur.
- Latency: req sampled at edge E0 -> ram_cs high during E0..E1 -> ack high during E2..E3.
- Priority (evaluated only in IDLE):
  - If vid_req: video wins.
  - Else if dma_req and starve_cnt >= STARVE_LIMIT: DMA wins.
  - Else if cpu_req: CPU wins.
  - Else if dma_req: DMA wins.
- Starvation counter (8-bit):
  - Increments, saturating at 255, on each IDLE grant to a non-DMA requester while dma_req=1.
  - Clears on a DMA grant, and in any cycle where dma_req=0.
- Request inputs are sampled only in IDLE. Requesters must hold addr/we/wdata stable from req rise until ack.
- A write returns the pre-write RAM contents in x_rdata.
- Reset mid-operation:
  - If rst_n falls while in ISSUE, the RAM still performs the access at that edge, since ram_cs was already high. A write therefore commits, but no ack is ever issued.
  - Requesters must treat reset as aborting any outstanding request.
- Simultaneous requests: losers keep req high and are served in later IDLE cycles. No request is lost or reordered within one requester.

Test Plan:
- Reset, then cpu_req write addr=0x0400 data=0xA5 -> ram_cs high for 1 cycle with ram_we=1, cpu_ack 2 cycles after the issue edge, cpu_rdata=0x00 (old data). A following CPU read of 0x0400 -> cpu_rdata=0xA5.
- vid_req and cpu_req rise on the same edge -> video served first (owner=1). CPU is granted in the IDLE immediately after vid_ack; total 8 cycles to both acks.
- Video held idle, CPU back-to-back requests, dma_req held, STARVE_LIMIT=8 -> DMA granted after exactly 8 CPU grants, then the counter is 0.
- Video continuous with dma_req held and the counter saturated -> video still always wins; dma_ack only after vid_req drops.
- rst_n low during ISSUE of a CPU write 0x5A to 0x0800 -> no cpu_ack, all outputs 0 next cycle. A later read of 0x0800 returns 0x5A.
- Requester keeps req high after ack (new request, new address) -> exactly one new grant, starting at the IDLE following ACK; never two acks per transaction.
